// File: rtl/cam_dvp_source_if.sv
// DVP output bundle of cam_dvp_source: sync, byte stream and per-frame status.
// master drives the stream, slave observes it.
interface cam_dvp_source_if;
  logic        cam_vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] frame_crc;

  modport master (
    output cam_vsync, href, p_data, frame_done, frame_count, frame_crc
  );

  modport slave (
    input cam_vsync, href, p_data, frame_done, frame_count, frame_crc
  );
endinterface

// File: rtl/cam_dvp_source.sv
// Synthetic OV7670-style DVP source: vsync/href/p_data byte stream of RGB565 test patterns.
// Define CAM_DVP_SOURCE_CRC_EN to compute a per-frame CRC-16/CCITT-FALSE of the active bytes.
module cam_dvp_source #(
  parameter int          FRAME_WIDTH  = 640,
  parameter int          FRAME_HEIGHT = 480,
  parameter int          HBLANK       = 144,
  parameter int          VSYNC_LINES  = 3,
  parameter int          VBACK_LINES  = 17,
  parameter int          VFRONT_LINES = 10,
  parameter logic [15:0] SOLID_COLOR  = 16'hF800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  cam_dvp_source_if.master dvp
);
  localparam int LINE_CYCLES = 2*FRAME_WIDTH + HBLANK;
  localparam int VSYNC_CYC   = VSYNC_LINES*LINE_CYCLES;
  localparam int VBACK_CYC   = VBACK_LINES*LINE_CYCLES;
  localparam int VFRONT_CYC  = VFRONT_LINES*LINE_CYCLES;
  localparam int MAX_LINES   = (VSYNC_LINES > VBACK_LINES) ?
                               ((VSYNC_LINES > VFRONT_LINES) ? VSYNC_LINES : VFRONT_LINES) :
                               ((VBACK_LINES > VFRONT_LINES) ? VBACK_LINES : VFRONT_LINES);
  localparam int TW = (MAX_LINES*LINE_CYCLES > 1) ? $clog2(MAX_LINES*LINE_CYCLES) : 1;
  localparam int BW = $clog2(2*FRAME_WIDTH);
  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  // IDLE wait enable | VSYNC vsync high | VBACK back porch | ACTIVE href bytes | HBLANK line gap | VFRONT front porch
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic [BW-1:0] bcnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   pcnt;
  logic [1:0]    pat;
  logic [15:0]   cur_pix, nxt_pix, line_pix;
  logic          vsync_start, frame_end, last_line;

  function automatic logic [15:0] pixel_of(input logic [1:0] p, input logic [15:0] px,
                                           input logic [15:0] py, input logic [15:0] pc);
    logic [15:0] bar;
    bar = px / 16'(FRAME_WIDTH/8);
    case (p)
      2'd0: begin
        case (bar)
          16'd0:   pixel_of = 16'hFFFF;
          16'd1:   pixel_of = 16'hFFE0;
          16'd2:   pixel_of = 16'h07FF;
          16'd3:   pixel_of = 16'h07E0;
          16'd4:   pixel_of = 16'hF81F;
          16'd5:   pixel_of = 16'hF800;
          16'd6:   pixel_of = 16'h001F;
          default: pixel_of = 16'h0000;
        endcase
      end
      2'd1:    pixel_of = {5'(px >> 3), 6'(py >> 2), 5'(px >> 3)};
      2'd2:    pixel_of = pc;
      default: pixel_of = SOLID_COLOR;
    endcase
  endfunction

  // Next-byte lookahead so p_data can be registered alongside href.
  always_comb begin
    cur_pix  = pixel_of(pat, 16'(x), 16'(y), pcnt);
    nxt_pix  = pixel_of(pat, 16'(x) + 16'd1, 16'(y), pcnt + 16'd1);
    line_pix = pixel_of(pat, 16'd0, (state == S_HBLANK) ? 16'(y) + 16'd1 : 16'd0, pcnt);
  end

  assign last_line   = (y == YW'(FRAME_HEIGHT-1));
  assign vsync_start = enable && ((state == S_IDLE) || ((state == S_VFRONT) && (tmr == '0)));
  assign frame_end   = (state == S_VFRONT) && (tmr == TW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      tmr             <= '0;
      bcnt            <= '0;
      x               <= '0;
      y               <= '0;
      pcnt            <= '0;
      pat             <= '0;
      dvp.cam_vsync   <= 1'b0;
      dvp.href        <= 1'b0;
      dvp.p_data      <= 8'h00;
      dvp.frame_done  <= 1'b0;
      dvp.frame_count <= 16'h0000;
    end else begin
      dvp.frame_done <= 1'b0;
      case (state)
        S_VSYNC: begin
          if (tmr == '0) begin
            state         <= S_VBACK;
            tmr           <= TW'(VBACK_CYC-1);
            dvp.cam_vsync <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_VBACK: begin
          if (tmr == '0) begin
            state      <= S_ACTIVE;
            x          <= '0;
            y          <= '0;
            bcnt       <= '0;
            dvp.href   <= 1'b1;
            dvp.p_data <= line_pix[15:8];
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (bcnt == BW'(2*FRAME_WIDTH-1)) begin
            state      <= S_HBLANK;
            tmr        <= TW'(HBLANK-1);
            pcnt       <= pcnt + 16'd1;
            dvp.href   <= 1'b0;
            dvp.p_data <= 8'h00;
          end else begin
            bcnt <= bcnt + 1'b1;
            if (!bcnt[0]) begin
              dvp.p_data <= cur_pix[7:0];
            end else begin
              x          <= x + 1'b1;
              pcnt       <= pcnt + 16'd1;
              dvp.p_data <= nxt_pix[15:8];
            end
          end
        end
        S_HBLANK: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (!last_line) begin
            state      <= S_ACTIVE;
            y          <= y + 1'b1;
            x          <= '0;
            bcnt       <= '0;
            dvp.href   <= 1'b1;
            dvp.p_data <= line_pix[15:8];
          end else begin
            state <= S_VFRONT;
            tmr   <= TW'(VFRONT_CYC-1);
          end
        end
        S_VFRONT: begin
          if (tmr == '0) state <= S_IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (frame_end) begin
        dvp.frame_done  <= 1'b1;
        dvp.frame_count <= dvp.frame_count + 16'd1;
      end

      // Entry from IDLE or straight out of VFRONT: back-to-back frames have no gap cycle.
      if (vsync_start) begin
        state         <= S_VSYNC;
        tmr           <= TW'(VSYNC_CYC-1);
        pat           <= pattern_sel;
        pcnt          <= '0;
        dvp.cam_vsync <= 1'b1;
      end
    end
  end

`ifdef CAM_DVP_SOURCE_CRC_EN
  logic [15:0] crc, crc_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc   <= 16'hFFFF;
      crc_q <= 16'h0000;
    end else begin
      if (vsync_start)   crc <= 16'hFFFF;
      else if (dvp.href) crc <= crc_byte(crc, dvp.p_data);
      if (frame_end)     crc_q <= crc;
    end
  end

  assign dvp.frame_crc = crc_q;
`else
  assign dvp.frame_crc = 16'h0000;
`endif
endmodule
